// File: rtl/iob_counter_mod.sv
// Up/down modulo counter: load, programmable step, runtime bound, wrap/saturate.
// Optional sticky overflow flag and its clear port: define IOB_COUNTER_MOD_OVF_EN.
module iob_counter_mod #(
   parameter int unsigned       DATA_W  = 32,
   parameter int unsigned       STEP_W  = 8,
   parameter logic [DATA_W-1:0] RST_VAL = '0,
   parameter int unsigned       MODE    = 0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              ce_i,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic              up_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              ld_i,
   input  logic [DATA_W-1:0] ld_val_i,
   input  logic [DATA_W-1:0] max_i,
   output logic [DATA_W-1:0] data_o,
   output logic              tc_o,
   output logic              zero_o
`ifdef IOB_COUNTER_MOD_OVF_EN
   ,
   input  logic              ovf_clr_i,
   output logic              ovf_o
`endif
);

   localparam int unsigned XW = DATA_W + 1;

   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_nxt;
   logic              tc_q;
   logic              tc_nxt;

   logic [XW-1:0] cur;
   logic [XW-1:0] lim;
   logic [XW-1:0] range;
   logic [XW-1:0] step_x;
   logic [XW-1:0] s;
   logic [XW-1:0] sum;
   logic          oor;

   // One extra bit so max_i + 1 and data + s never lose a carry
   assign cur    = {1'b0, data_q};
   assign lim    = {1'b0, max_i};
   assign range  = lim + XW'(1);
   assign step_x = XW'(step_i);
   assign s      = (step_x < range) ? step_x : range;
   assign sum    = cur + s;
   assign oor    = data_q > max_i;

   always_comb begin
      data_nxt = data_q;
      tc_nxt   = 1'b0;
      if (clr_i) begin
         data_nxt = RST_VAL;
      end else if (ld_i) begin
         data_nxt = (ld_val_i > max_i) ? max_i : ld_val_i;
      end else if (en_i && (s != '0)) begin
         if (oor) begin
            tc_nxt   = 1'b1;
            data_nxt = up_i ? '0 : max_i;
         end else if (up_i) begin
            if (sum > lim) begin
               tc_nxt   = 1'b1;
               data_nxt = (MODE == 1) ? max_i
                                      : DATA_W'(sum - range);
            end else begin
               data_nxt = DATA_W'(sum);
            end
         end else begin
            if (s > cur) begin
               tc_nxt   = 1'b1;
               data_nxt = (MODE == 1) ? '0
                                      : DATA_W'(cur + range - s);
            end else begin
               data_nxt = DATA_W'(cur - s);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         data_q <= RST_VAL;
         tc_q   <= 1'b0;
      end else if (ce_i) begin
         data_q <= data_nxt;
         tc_q   <= tc_nxt;
      end
   end

   assign data_o = data_q;
   assign tc_o   = tc_q;
   assign zero_o = (data_q == '0);

`ifdef IOB_COUNTER_MOD_OVF_EN
   logic ovf_q;

   // A new terminal count beats a concurrent flag clear
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ovf_q <= 1'b0;
      end else if (ce_i) begin
         if (clr_i) begin
            ovf_q <= 1'b0;
         end else if (tc_nxt) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_iob_counter_mod.sv
// Bench for iob_counter_mod: wrap and saturate instances share stimulus
// and are compared against an arithmetic reference model.
module tb_iob_counter_mod;

   logic       clk = 1'b0;
   logic       rst_n, ce, clr, en, up, ld;
   logic [7:0] step, ld_val, max;
   logic [7:0] d0, d1;
   logic       tc0, tc1, z0, z1;
`ifdef IOB_COUNTER_MOD_OVF_EN
   logic       ovf_clr;
   logic       ov0, ov1;
`endif

   int n_run  = 0;
   int n_fail = 0;

   int m0 = 0, m1 = 0;
   bit t0 = 0, t1 = 0;
   bit o0 = 0, o1 = 0;

   always #5 clk = ~clk;

   iob_counter_mod #(
      .DATA_W(8), .STEP_W(8), .RST_VAL(8'd0), .MODE(0)
   ) u_wrap (
      .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .clr_i(clr),
      .en_i(en), .up_i(up), .step_i(step), .ld_i(ld),
      .ld_val_i(ld_val), .max_i(max),
      .data_o(d0), .tc_o(tc0), .zero_o(z0)
`ifdef IOB_COUNTER_MOD_OVF_EN
      , .ovf_clr_i(ovf_clr), .ovf_o(ov0)
`endif
   );

   iob_counter_mod #(
      .DATA_W(8), .STEP_W(8), .RST_VAL(8'd0), .MODE(1)
   ) u_sat (
      .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .clr_i(clr),
      .en_i(en), .up_i(up), .step_i(step), .ld_i(ld),
      .ld_val_i(ld_val), .max_i(max),
      .data_o(d1), .tc_o(tc1), .zero_o(z1)
`ifdef IOB_COUNTER_MOD_OVF_EN
      , .ovf_clr_i(ovf_clr), .ovf_o(ov1)
`endif
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: count range [0,mx], result from signed arithmetic
   task automatic model(input int mode, inout int d, inout bit t,
                        inout bit o);
      int mx, r, s, u;
      bit ovc;
      mx = int'(max);
      r  = mx + 1;
      s  = (int'(step) < r) ? int'(step) : r;
`ifdef IOB_COUNTER_MOD_OVF_EN
      ovc = ovf_clr;
`else
      ovc = 1'b0;
`endif
      if (!rst_n) begin
         d = 0; t = 0; o = 0;
      end else if (ce) begin
         t = 0;
         if (clr) begin
            d = 0; o = 0;
         end else if (ld) begin
            d = (int'(ld_val) > mx) ? mx : int'(ld_val);
         end else if (en && s > 0) begin
            if (d > mx) begin
               t = 1;
               d = up ? 0 : mx;
            end else begin
               u = up ? d + s : d - s;
               if (u < 0 || u > mx) begin
                  t = 1;
                  if (mode == 1) d = (u < 0) ? 0 : mx;
                  else d = ((u % r) + r) % r;
               end else begin
                  d = u;
               end
            end
         end
         if (!clr) begin
            if (t) o = 1;
            else if (ovc) o = 0;
         end
      end
   endtask

   task automatic tick(string tag);
      model(0, m0, t0, o0);
      model(1, m1, t1, o1);
      @(posedge clk);
      #1;
      chk({tag, "_d0"}, d0, m0);
      chk({tag, "_tc0"}, tc0, t0);
      chk({tag, "_z0"}, z0, m0 == 0);
      chk({tag, "_d1"}, d1, m1);
      chk({tag, "_tc1"}, tc1, t1);
      chk({tag, "_z1"}, z1, m1 == 0);
`ifdef IOB_COUNTER_MOD_OVF_EN
      chk({tag, "_ov0"}, ov0, o0);
      chk({tag, "_ov1"}, ov1, o1);
`endif
   endtask

   task automatic idle();
      rst_n = 1; ce = 1; clr = 0; en = 0; ld = 0;
`ifdef IOB_COUNTER_MOD_OVF_EN
      ovf_clr = 0;
`endif
   endtask

   task automatic load(input int v);
      idle();
      ld = 1; ld_val = 8'(v);
      tick("load");
      ld = 0;
   endtask

   initial begin
      idle();
      up = 1; step = 1; max = 9; ld_val = 0;
      rst_n = 0;
      tick("reset");
      chk("reset_d", d0, 0);
      chk("reset_tc", tc0, 0);
      chk("reset_z", z0, 1);

      // Wrap sequence 1..9,0,1,2
      idle(); en = 1;
      for (int i = 1; i <= 12; i++) begin
         tick("t1");
         chk("t1_seq", d0, i % 10);
         chk("t1_tc", tc0, i == 10);
      end

      // Down wrap and oversized up step
      load(1);
      idle(); en = 1; up = 0; step = 3;
      tick("t2dn");
      chk("t2_down", d0, 8);
      chk("t2_down_tc", tc0, 1);
      load(4);
      idle(); en = 1; up = 1; step = 15;
      tick("t2up");
      chk("t2_bigstep", d0, 4);
      chk("t2_bigstep_tc", tc0, 1);

      // Priorities
      idle(); ld = 1; en = 1; ld_val = 200; step = 1;
      tick("t3ld");
      chk("t3_ld_clamp", d0, 9);
      chk("t3_ld_tc", tc0, 0);
      idle(); clr = 1; ld = 1;
      tick("t3clr");
      chk("t3_clr", d0, 0);
      load(5);
      idle(); ce = 0; ld = 1; ld_val = 2;
      tick("t3ce");
      chk("t3_ce_hold", d0, 5);

      // Saturation
      load(8);
      idle(); en = 1; up = 1; step = 4;
      tick("t4a");
      chk("t4_sat_hi", d1, 9);
      chk("t4_sat_hi_tc", tc1, 1);
      tick("t4b");
      chk("t4_sat_again", d1, 9);
      chk("t4_sat_again_tc", tc1, 1);
      load(2);
      idle(); en = 1; up = 0; step = 4;
      tick("t4c");
      chk("t4_sat_lo", d1, 0);
      chk("t4_sat_lo_tc", tc1, 1);

      // Reset mid-count, then out-of-range after lowering max
      load(8);
      idle(); en = 1; up = 1; step = 7;
      tick("t5a");
      chk("t5_pre_d", d0, 5);
      chk("t5_pre_tc", tc0, 1);
      rst_n = 0;
      tick("t5rst");
      chk("t5_rst_d", d0, 0);
      chk("t5_rst_tc", tc0, 0);
      load(7);
      max = 3;
      idle(); en = 1; up = 1; step = 1;
      tick("t5oor");
      chk("t5_oor_d0", d0, 0);
      chk("t5_oor_d1", d1, 0);
      chk("t5_oor_tc", tc0, 1);

      // Degenerate bounds
      max = 0;
      tick("max0");
      chk("max0_tc", tc0, 1);
      max = 8'hff; step = 8'hff;
      load(10);
      idle(); en = 1;
      tick("maxff");
      chk("maxff_d", d0, 9);

`ifdef IOB_COUNTER_MOD_OVF_EN
      idle(); clr = 1;
      tick("ovclr");
      max = 9; step = 9; up = 1;
      idle(); en = 1;
      tick("ov_a");
      tick("ov_b");
      chk("ovf_set", ov0, 1);
      en = 0;
      tick("ov_hold");
      chk("ovf_sticky", ov0, 1);
      en = 1; ovf_clr = 1;
      tick("ov_c");
      chk("ovf_set_wins", ov0, 1);
      en = 0;
      tick("ov_d");
      chk("ovf_cleared", ov0, 0);
`endif

      // Randomized run
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         ce    = ($urandom_range(0, 9) != 0);
         clr   = ($urandom_range(0, 19) == 0);
         ld    = ($urandom_range(0, 9) == 0);
         en    = ($urandom_range(0, 4) != 0);
         up    = 1'($urandom_range(0, 1));
         ld_val = 8'($urandom);
         case ($urandom_range(0, 3))
            0: step = 8'($urandom);
            1: step = 0;
            default: step = 8'($urandom_range(1, 5));
         endcase
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
               0: max = 0;
               1: max = 8'hff;
               2: max = 8'($urandom_range(1, 20));
               default: max = 8'($urandom);
            endcase
         end
`ifdef IOB_COUNTER_MOD_OVF_EN
         ovf_clr = ($urandom_range(0, 7) == 0);
`endif
         tick("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
